// File: rtl/viterbi_decode_controller_if.sv
// rtl/viterbi_decode_controller_if.sv - command, coded-bit, ACS and traceback bundle for the Viterbi controller
//
// Purpose: groups every non-clock/reset signal of viterbi_decode_controller.
// Ports (signals):
//   start, block_len, abort      block command and synchronous abort
//   in_valid, in_bit, in_ready   serial coded-bit handshake from the deinterleaver
//   acs_en, acs_first, acs_pair, acs_step   per-step ACS strobe and payload
//   tb_start, tb_steps, tb_done  traceback request / completion
//   busy, done, err_len          block status
// Modports: slave = the controller, master = the surrounding receiver chain.

interface viterbi_decode_controller_if #(
  parameter int CNT_W = 10
);
  logic             start;
  logic [CNT_W-1:0] block_len;
  logic             abort;
  logic             in_valid;
  logic             in_bit;
  logic             in_ready;
  logic             acs_en;
  logic             acs_first;
  logic [1:0]       acs_pair;
  logic [CNT_W-1:0] acs_step;
  logic             tb_start;
  logic [CNT_W-1:0] tb_steps;
  logic             tb_done;
  logic             busy;
  logic             done;
  logic             err_len;

  modport master (
    output start, block_len, abort, in_valid, in_bit, tb_done,
    input  in_ready, acs_en, acs_first, acs_pair, acs_step,
           tb_start, tb_steps, busy, done, err_len
  );

  modport slave (
    input  start, block_len, abort, in_valid, in_bit, tb_done,
    output in_ready, acs_en, acs_first, acs_pair, acs_step,
           tb_start, tb_steps, busy, done, err_len
  );
endinterface

// File: rtl/viterbi_decode_controller.sv
// rtl/viterbi_decode_controller.sv - per-block sequencer for the Viterbi ACS and traceback datapath
//
// Purpose: accepts a block command, pulls 2*len serial coded bits, issues one
// ACS strobe per bit pair with its step index, then requests traceback and
// waits for its completion pulse.
// Ports:
//   Clock  rising-edge system clock
//   Reset  asynchronous, active-high reset
//   bus    viterbi_decode_controller_if.slave (command, coded-bit stream,
//          ACS strobe, traceback handshake, status)

module viterbi_decode_controller #(
  parameter int MAX_LENGTH = 192,
  parameter int CNT_W      = 10
) (
  input  logic                          Clock,
  input  logic                          Reset,
  viterbi_decode_controller_if.slave    bus
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] PAIR_A  = 3'd1;
  localparam logic [2:0] PAIR_B  = 3'd2;
  localparam logic [2:0] TB_REQ  = 3'd3;
  localparam logic [2:0] TB_WAIT = 3'd4;

  localparam logic [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] MAX_LEN = MAX_LENGTH[CNT_W-1:0];

  logic [2:0]       state;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] step_q;
  logic             bit_a_q;

  logic             acs_en_q;
  logic             acs_first_q;
  logic [1:0]       acs_pair_q;
  logic [CNT_W-1:0] acs_step_q;
  logic             tb_start_q;
  logic [CNT_W-1:0] tb_steps_q;
  logic             busy_q;
  logic             done_q;
  logic             err_len_q;

  logic             accept;
  logic             len_illegal;
  logic             last_step;

  // Upstream is only ever asked for bits while a pair is being collected.
  assign bus.in_ready = (state == PAIR_A) || (state == PAIR_B);
  assign accept       = bus.in_valid && bus.in_ready;
  assign len_illegal  = (bus.block_len == '0) || (bus.block_len > MAX_LEN);
  // len is at least 1 whenever this is consulted, so len-1 cannot underflow.
  assign last_step    = (step_q == (len_q - ONE));

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      len_q       <= '0;
      step_q      <= '0;
      bit_a_q     <= 1'b0;
      acs_en_q    <= 1'b0;
      acs_first_q <= 1'b0;
      acs_pair_q  <= 2'b00;
      acs_step_q  <= '0;
      tb_start_q  <= 1'b0;
      tb_steps_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_len_q   <= 1'b0;
    end else begin
      acs_en_q    <= 1'b0;
      acs_first_q <= 1'b0;
      tb_start_q  <= 1'b0;
      done_q      <= 1'b0;
      err_len_q   <= 1'b0;

      if (bus.abort) begin
        // Any half-collected pair is dropped; the next block restarts cleanly.
        state   <= IDLE;
        busy_q  <= 1'b0;
        bit_a_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              if (len_illegal) begin
                err_len_q <= 1'b1;
              end else begin
                len_q  <= bus.block_len;
                step_q <= '0;
                busy_q <= 1'b1;
                state  <= PAIR_A;
              end
            end
          end

          PAIR_A: begin
            if (accept) begin
              bit_a_q <= bus.in_bit;
              state   <= PAIR_B;
            end
          end

          PAIR_B: begin
            if (accept) begin
              acs_en_q    <= 1'b1;
              acs_pair_q  <= {bit_a_q, bus.in_bit};
              acs_step_q  <= step_q;
              acs_first_q <= (step_q == '0);
              if (last_step) begin
                state <= TB_REQ;
              end else begin
                step_q <= step_q + ONE;
                state  <= PAIR_A;
              end
            end
          end

          TB_REQ: begin
            tb_start_q <= 1'b1;
            tb_steps_q <= len_q;
            state      <= TB_WAIT;
          end

          TB_WAIT: begin
            // tb_start is high during the first TB_WAIT cycle, so a completion
            // pulse coincident with the request is still honoured.
            if (bus.tb_done) begin
              done_q <= 1'b1;
              busy_q <= 1'b0;
              state  <= IDLE;
            end
          end

          default: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.acs_en    = acs_en_q;
  assign bus.acs_first = acs_first_q;
  assign bus.acs_pair  = acs_pair_q;
  assign bus.acs_step  = acs_step_q;
  assign bus.tb_start  = tb_start_q;
  assign bus.tb_steps  = tb_steps_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err_len   = err_len_q;

endmodule

// File: tb/tb_viterbi_decode_controller.sv
// tb/tb_viterbi_decode_controller.sv - self-checking bench for viterbi_decode_controller
//
// Purpose: drives blocks of random coded bits with random backpressure and
// compares the observed ACS strobes, traceback request and status pulses
// against pairs/steps derived directly from the bit sequence.
// Ports: none (top-level bench).

module tb_viterbi_decode_controller;
  localparam int CNT_W      = 10;
  localparam int MAX_LENGTH = 192;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  always #5 Clock = ~Clock;

  viterbi_decode_controller_if #(.CNT_W(CNT_W)) bus();

  viterbi_decode_controller #(.MAX_LENGTH(MAX_LENGTH), .CNT_W(CNT_W)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  int vectors    = 0;
  int miscompares = 0;

  int cycle = 0;
  logic [1:0] obs_pair[$];
  int         obs_step[$];
  bit         obs_first[$];
  int         obs_cyc[$];
  int tbs_cnt, tbs_cyc, tbs_steps, done_cnt, err_cnt, first_bad, ready_bad;

  always @(negedge Clock) begin
    cycle++;
    if (bus.acs_en === 1'b1) begin
      obs_pair.push_back(bus.acs_pair);
      obs_step.push_back(int'(bus.acs_step));
      obs_first.push_back(bus.acs_first);
      obs_cyc.push_back(cycle);
    end
    if (bus.tb_start === 1'b1) begin
      tbs_cnt++;
      tbs_cyc   = cycle;
      tbs_steps = int'(bus.tb_steps);
    end
    if (bus.done === 1'b1) done_cnt++;
    if (bus.err_len === 1'b1) err_cnt++;
    if (bus.acs_first === 1'b1 && bus.acs_en !== 1'b1) first_bad++;
    if (bus.in_ready === 1'b1 && bus.busy !== 1'b1) ready_bad++;
  end

  task automatic clear_mon();
    obs_pair.delete();
    obs_step.delete();
    obs_first.delete();
    obs_cyc.delete();
    tbs_cnt = 0; tbs_cyc = 0; tbs_steps = -1;
    done_cnt = 0; err_cnt = 0; first_bad = 0; ready_bad = 0;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_start(input int len);
    bus.start     = 1'b1;
    bus.block_len = len[CNT_W-1:0];
    tick();
    bus.start     = 1'b0;
  endtask

  task automatic rand_bits(input int n, output bit q[$]);
    q.delete();
    for (int i = 0; i < n; i++) q.push_back(bit'($urandom_range(1)));
  endtask

  // Presents bits in order; a bit counts as consumed only on an edge where
  // both valid and ready were high. spur_at pulses start and tb_done once.
  task automatic feed(input bit bits[$], input int pct, input int spur_at, output int acc);
    int  idx = 0;
    int  guard = 0;
    bit  v, r;
    while (idx < bits.size() && guard < 5000) begin
      v = ($urandom_range(99) < pct);
      bus.in_valid = v;
      bus.in_bit   = v ? bits[idx] : bit'($urandom_range(1));
      bus.start    = (guard == spur_at);
      bus.tb_done  = (guard == spur_at);
      if (guard == spur_at) bus.block_len = 10'd5;
      r = bus.in_ready;
      tick();
      if (v && r) idx++;
      guard++;
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    bus.tb_done  = 1'b0;
    acc = idx;
  endtask

  task automatic wait_tb_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.tb_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic pulse_tb_done();
    bus.tb_done = 1'b1;
    tick();
    bus.tb_done = 1'b0;
  endtask

  task automatic check_steps(input string name, input bit bits[$], input int len);
    vectors++;
    if (obs_pair.size() != len) begin
      miscompares++;
      $display("FAIL %s_count: got %0d strobes, expected %0d", name, obs_pair.size(), len);
    end
    for (int k = 0; k < len && k < obs_pair.size(); k++) begin
      logic [1:0] exp_pair;
      exp_pair = {bits[2*k], bits[2*k+1]};
      vectors++;
      if (obs_pair[k] !== exp_pair || obs_step[k] != k || obs_first[k] !== (k == 0)) begin
        miscompares++;
        $display("FAIL %s_step%0d: got pair=%b step=%0d first=%0d, expected pair=%b step=%0d first=%0d",
                 name, k, obs_pair[k], obs_step[k], obs_first[k], exp_pair, k, (k == 0));
      end
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (3) @(posedge Clock);
    #1;
    vectors++;
    if ({bus.in_ready, bus.acs_en, bus.acs_first, bus.acs_pair, bus.acs_step, bus.tb_start,
         bus.tb_steps, bus.busy, bus.done, bus.err_len} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got nonzero outputs busy=%b ready=%b tb_steps=%0d acs_step=%0d, expected all 0",
               bus.busy, bus.in_ready, bus.tb_steps, bus.acs_step);
    end
    Reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    bit bits[$];
    int acc;
    bit ok;
    clear_mon();
    bits = '{1, 1, 0, 1, 0, 0};
    do_start(3);
    vectors++;
    if (bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_busy: got %b, expected 1", bus.busy);
    end
    feed(bits, 100, -1, acc);
    wait_tb_start(ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL basic_tb_start_timeout: got no tb_start, expected one");
    end
    repeat (5) tick();
    vectors++;
    if (bus.tb_steps !== 10'd3) begin
      miscompares++;
      $display("FAIL basic_tb_steps_held: got %0d, expected 3", bus.tb_steps);
    end
    pulse_tb_done();
    vectors++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_done: got done=%b busy=%b, expected done=1 busy=0", bus.done, bus.busy);
    end
    tick();
    check_steps("basic", bits, 3);
    vectors++;
    if (obs_cyc.size() == 3 && (obs_cyc[1] - obs_cyc[0] != 2 || obs_cyc[2] - obs_cyc[1] != 2)) begin
      miscompares++;
      $display("FAIL basic_spacing: got gaps %0d,%0d, expected 2,2", obs_cyc[1] - obs_cyc[0], obs_cyc[2] - obs_cyc[1]);
    end
    vectors++;
    if (tbs_cnt != 1 || obs_cyc.size() != 3 || tbs_cyc != obs_cyc[obs_cyc.size()-1] + 1 || tbs_steps != 3) begin
      miscompares++;
      $display("FAIL basic_tb_start: got count=%0d cyc=%0d steps=%0d, expected count=1 one cycle after last strobe steps=3",
               tbs_cnt, tbs_cyc, tbs_steps);
    end
    vectors++;
    if (done_cnt != 1 || bus.done !== 1'b0 || first_bad != 0) begin
      miscompares++;
      $display("FAIL basic_done_pulse: got done_cnt=%0d done=%b first_bad=%0d, expected 1,0,0", done_cnt, bus.done, first_bad);
    end
  endtask

  task automatic test_len_err();
    int lens[2] = '{0, MAX_LENGTH + 1};
    foreach (lens[i]) begin
      clear_mon();
      do_start(lens[i]);
      vectors++;
      if (bus.err_len !== 1'b1 || bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL len_err_%0d: got err=%b busy=%b ready=%b, expected 1,0,0", lens[i], bus.err_len, bus.busy, bus.in_ready);
      end
      tick();
      tick();
      vectors++;
      if (err_cnt != 1 || bus.busy !== 1'b0) begin
        miscompares++;
        $display("FAIL len_err_pulse_%0d: got %0d pulses busy=%b, expected 1 pulse busy=0", lens[i], err_cnt, bus.busy);
      end
    end
  endtask

  task automatic test_max_len();
    bit bits[$];
    int acc;
    bit ok;
    clear_mon();
    rand_bits(2 * MAX_LENGTH, bits);
    do_start(MAX_LENGTH);
    feed(bits, 100, -1, acc);
    wait_tb_start(ok);
    // completion coincident with the traceback request
    pulse_tb_done();
    vectors++;
    if (!ok || bus.done !== 1'b1) begin
      miscompares++;
      $display("FAIL max_done_same_cycle: got tb_start=%0d done=%b, expected 1,1", ok, bus.done);
    end
    tick();
    check_steps("max", bits, MAX_LENGTH);
    vectors++;
    if (obs_step.size() == 0 || obs_step[obs_step.size()-1] != MAX_LENGTH - 1 || tbs_steps != MAX_LENGTH || err_cnt != 0) begin
      miscompares++;
      $display("FAIL max_last: got last step=%0d tb_steps=%0d err=%0d, expected %0d,%0d,0",
               obs_step.size() ? obs_step[obs_step.size()-1] : -1, tbs_steps, err_cnt, MAX_LENGTH - 1, MAX_LENGTH);
    end
  endtask

  task automatic test_backpressure();
    bit bits[$];
    int acc;
    bit ok;
    clear_mon();
    rand_bits(48, bits);
    do_start(24);
    feed(bits, 45, -1, acc);
    wait_tb_start(ok);
    tick();
    pulse_tb_done();
    tick();
    check_steps("bp", bits, 24);
    vectors++;
    if (!ok || acc != 48 || ready_bad != 0 || done_cnt != 1 || tbs_steps != 24) begin
      miscompares++;
      $display("FAIL bp_status: got tb=%0d consumed=%0d ready_bad=%0d done=%0d tb_steps=%0d, expected 1,48,0,1,24",
               ok, acc, ready_bad, done_cnt, tbs_steps);
    end
  endtask

  task automatic test_spurious();
    bit bits[$];
    int acc;
    bit ok;
    clear_mon();
    rand_bits(16, bits);
    do_start(8);
    feed(bits, 80, 5, acc);
    wait_tb_start(ok);
    vectors++;
    if (done_cnt != 0 || err_cnt != 0 || bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL spur_ignored: got done=%0d err=%0d busy=%b, expected 0,0,1", done_cnt, err_cnt, bus.busy);
    end
    tick();
    pulse_tb_done();
    tick();
    check_steps("spur", bits, 8);
    vectors++;
    if (!ok || done_cnt != 1 || tbs_steps != 8) begin
      miscompares++;
      $display("FAIL spur_complete: got tb=%0d done=%0d tb_steps=%0d, expected 1,1,8", ok, done_cnt, tbs_steps);
    end
  endtask

  task automatic test_abort();
    bit bits[$];
    bit bits2[$];
    int acc;
    bit ok;
    clear_mon();
    bus.start = 1'b1;
    bus.block_len = 10'd4;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    vectors++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_beats_start: got busy=%b ready=%b, expected 0,0", bus.busy, bus.in_ready);
    end
    rand_bits(3, bits);
    do_start(4);
    feed(bits, 100, -1, acc);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    vectors++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_idle: got busy=%b ready=%b, expected 0,0", bus.busy, bus.in_ready);
    end
    repeat (4) tick();
    vectors++;
    if (tbs_cnt != 0 || done_cnt != 0 || obs_pair.size() != 1) begin
      miscompares++;
      $display("FAIL abort_quiet: got tb_start=%0d done=%0d strobes=%0d, expected 0,0,1", tbs_cnt, done_cnt, obs_pair.size());
    end
    clear_mon();
    rand_bits(4, bits2);
    do_start(2);
    feed(bits2, 100, -1, acc);
    wait_tb_start(ok);
    tick();
    pulse_tb_done();
    tick();
    check_steps("post_abort", bits2, 2);
    vectors++;
    if (!ok || done_cnt != 1 || tbs_steps != 2) begin
      miscompares++;
      $display("FAIL post_abort_complete: got tb=%0d done=%0d tb_steps=%0d, expected 1,1,2", ok, done_cnt, tbs_steps);
    end
  endtask

  task automatic test_async_reset();
    bit bits[$];
    int acc;
    bit ok;
    clear_mon();
    rand_bits(4, bits);
    do_start(2);
    feed(bits, 100, -1, acc);
    wait_tb_start(ok);
    tick();
    #2;
    Reset = 1'b1;
    #1;
    vectors++;
    if (!ok || {bus.in_ready, bus.acs_en, bus.acs_first, bus.acs_pair, bus.acs_step, bus.tb_start,
                bus.tb_steps, bus.busy, bus.done, bus.err_len} !== '0) begin
      miscompares++;
      $display("FAIL async_reset: got busy=%b tb_steps=%0d acs_step=%0d tb=%0d, expected all 0 mid-cycle",
               bus.busy, bus.tb_steps, bus.acs_step, ok);
    end
    tick();
    Reset = 1'b0;
    tick();
    clear_mon();
    pulse_tb_done();
    repeat (3) tick();
    vectors++;
    if (done_cnt != 0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset_no_done: got done=%0d busy=%b, expected 0,0", done_cnt, bus.busy);
    end
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.block_len = '0;
    bus.abort     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_bit    = 1'b0;
    bus.tb_done   = 1'b0;
    clear_mon();
    test_reset();
    test_basic();
    test_len_err();
    test_max_len();
    test_backpressure();
    test_spurious();
    test_abort();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
